// File: rtl/cia_timer.sv
// cia_timer: two 16-bit CIA-style interval timers + ICR driving 6502 IRQ; CIA_TIMER_CASCADE_EN lets TB count TA underflows.
// Latency: register writes visible next cycle; reads return on dout one cycle after cs&~we; irq follows flag/mask state.
// Backpressure: none; the CPU bus is always accepted, and dout holds its last value between reads.
module cia_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       cs,
    input  logic       we,
    input  logic [3:0] reg_addr,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic       irq
);

    localparam logic [3:0] TA_LO = 4'h4;
    localparam logic [3:0] TA_HI = 4'h5;
    localparam logic [3:0] TB_LO = 4'h6;
    localparam logic [3:0] TB_HI = 4'h7;
    localparam logic [3:0] ICR   = 4'hD;
    localparam logic [3:0] CRA   = 4'hE;
    localparam logic [3:0] CRB   = 4'hF;

    logic [15:0] ta_cnt, ta_lat, tb_cnt, tb_lat;
    logic        ta_start, ta_oneshot, tb_start, tb_oneshot, tb_cascade;
    logic [1:0]  icr_mask, icr_flag;
    logic        wr, rd;
    logic        ta_ev, ta_uf, tb_ev, tb_uf;
    logic        ta_load, tb_load;
    logic [15:0] ta_load_val, tb_load_val;
    logic [7:0]  rdata;

    assign wr = cs & we;
    assign rd = cs & ~we;

    assign ta_ev = tick & ta_start;
    assign ta_uf = ta_ev & (ta_cnt == 16'h0000);
`ifdef CIA_TIMER_CASCADE_EN
    assign tb_ev = tb_start & (tb_cascade ? ta_uf : tick);
`else
    assign tb_ev      = tb_start & tick;
    assign tb_cascade = 1'b0;
`endif
    assign tb_uf = tb_ev & (tb_cnt == 16'h0000);

    // A load (HI write while stopped, or FORCE_LOAD) takes priority over counting.
    assign ta_load     = wr & (((reg_addr == TA_HI) & ~ta_start) | ((reg_addr == CRA) & di[4]));
    assign tb_load     = wr & (((reg_addr == TB_HI) & ~tb_start) | ((reg_addr == CRB) & di[4]));
    assign ta_load_val = (reg_addr == TA_HI) ? {di, ta_lat[7:0]} : ta_lat;
    assign tb_load_val = (reg_addr == TB_HI) ? {di, tb_lat[7:0]} : tb_lat;

    assign irq = |(icr_flag & icr_mask);

    always_comb begin
        rdata = 8'h00;
        case (reg_addr)
            TA_LO:   rdata = ta_cnt[7:0];
            TA_HI:   rdata = ta_cnt[15:8];
            TB_LO:   rdata = tb_cnt[7:0];
            TB_HI:   rdata = tb_cnt[15:8];
            ICR:     rdata = {irq, 5'b00000, icr_flag};
            CRA:     rdata = {4'b0000, ta_oneshot, 2'b00, ta_start};
            CRB:     rdata = {1'b0, tb_cascade, 2'b00, tb_oneshot, 2'b00, tb_start};
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ta_cnt     <= 16'hFFFF;
            ta_lat     <= 16'hFFFF;
            tb_cnt     <= 16'hFFFF;
            tb_lat     <= 16'hFFFF;
            ta_start   <= 1'b0;
            ta_oneshot <= 1'b0;
            tb_start   <= 1'b0;
            tb_oneshot <= 1'b0;
            icr_mask   <= 2'b00;
            icr_flag   <= 2'b00;
            dout       <= 8'h00;
        end else begin
            if (ta_load)
                ta_cnt <= ta_load_val;
            else if (ta_ev)
                ta_cnt <= ta_uf ? ta_lat : ta_cnt - 16'd1;

            if (tb_load)
                tb_cnt <= tb_load_val;
            else if (tb_ev)
                tb_cnt <= tb_uf ? tb_lat : tb_cnt - 16'd1;

            if (ta_uf & ta_oneshot)
                ta_start <= 1'b0;
            if (tb_uf & tb_oneshot)
                tb_start <= 1'b0;

            // CR writes land after the one-shot stop so the CPU's value wins.
            if (wr) begin
                case (reg_addr)
                    TA_LO: ta_lat[7:0]  <= di;
                    TA_HI: ta_lat[15:8] <= di;
                    TB_LO: tb_lat[7:0]  <= di;
                    TB_HI: tb_lat[15:8] <= di;
                    ICR:   icr_mask     <= di[7] ? (icr_mask | di[1:0]) : (icr_mask & ~di[1:0]);
                    CRA: begin
                        ta_start   <= di[0];
                        ta_oneshot <= di[3];
                    end
                    CRB: begin
                        tb_start   <= di[0];
                        tb_oneshot <= di[3];
                    end
                    default: ;
                endcase
            end

            // A new underflow outranks the read-clear so no event is lost.
            icr_flag <= ((rd && (reg_addr == ICR)) ? 2'b00 : icr_flag) | {tb_uf, ta_uf};

            if (rd)
                dout <= rdata;
        end
    end

`ifdef CIA_TIMER_CASCADE_EN
    always_ff @(posedge clk) begin
        if (reset)
            tb_cascade <= 1'b0;
        else if (wr && (reg_addr == CRB))
            tb_cascade <= di[6];
    end
`endif

endmodule

// File: tb/tb_cia_timer.sv
// Self-checking bench for cia_timer: directed scenarios with fixed expectations, then random bus/tick traffic vs a timer model.
module tb_cia_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [3:0] reg_addr = 4'h0;
    logic [7:0] di = 8'h00;
    logic [7:0] dout;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    cia_timer dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .cs       (cs),
        .we       (we),
        .reg_addr (reg_addr),
        .di       (di),
        .dout     (dout),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 = timer A, 1 = timer B.
    logic [15:0] m_cnt [2];
    logic [15:0] m_lat [2];
    bit          m_run [2];
    bit          m_one [2];
    bit          m_cas;
    bit   [1:0]  m_mask;
    bit   [1:0]  m_flag;
    logic [7:0]  m_do;

    function automatic bit m_irq();
        return |(m_flag & m_mask);
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
            4'h4: return m_cnt[0][7:0];
            4'h5: return m_cnt[0][15:8];
            4'h6: return m_cnt[1][7:0];
            4'h7: return m_cnt[1][15:8];
            4'hD: return {m_irq(), 5'b00000, m_flag};
            4'hE: return {4'b0000, m_one[0], 2'b00, m_run[0]};
            4'hF: return {1'b0, m_cas, 2'b00, m_one[1], 2'b00, m_run[1]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        bit       wr, rd, ev, load;
        bit [1:0] uf;
        if (reset) begin
            for (int t = 0; t < 2; t++) begin
                m_cnt[t] = 16'hFFFF;
                m_lat[t] = 16'hFFFF;
                m_run[t] = 0;
                m_one[t] = 0;
            end
            m_cas = 0; m_mask = 0; m_flag = 0; m_do = 8'h00;
            return;
        end
        wr = cs && we;
        rd = cs && !we;
        if (rd) m_do = m_read(reg_addr);
        uf = 2'b00;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) ev = tick && m_run[0];
            else        ev = m_run[1] && (m_cas ? uf[0] : tick);
            load = wr && (((int'(reg_addr) == 5 + 2 * t) && !m_run[t]) ||
                          ((int'(reg_addr) == 14 + t) && di[4]));
            if (ev && m_cnt[t] == 16'd0) begin
                uf[t] = 1'b1;
                if (m_one[t]) m_run[t] = 0;
            end
            if (load)
                m_cnt[t] = (int'(reg_addr) == 14 + t) ? m_lat[t] : {di, m_lat[t][7:0]};
            else if (ev)
                m_cnt[t] = uf[t] ? m_lat[t] : m_cnt[t] - 16'd1;
        end
        if (wr) begin
            case (reg_addr)
                4'h4: m_lat[0][7:0]  = di;
                4'h5: m_lat[0][15:8] = di;
                4'h6: m_lat[1][7:0]  = di;
                4'h7: m_lat[1][15:8] = di;
                4'hD: m_mask = di[7] ? (m_mask | di[1:0]) : (m_mask & ~di[1:0]);
                4'hE: begin m_run[0] = di[0]; m_one[0] = di[3]; end
                4'hF: begin
                    m_run[1] = di[0];
                    m_one[1] = di[3];
`ifdef CIA_TIMER_CASCADE_EN
                    m_cas = di[6];
`endif
                end
                default: ;
            endcase
        end
        if (rd && reg_addr == 4'hD) m_flag = 2'b00;
        m_flag = m_flag | uf;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d, input logic tk);
        cs = 1; we = 1; reg_addr = a; di = d; tick = tk;
        clk_step();
        cs = 0; we = 0; tick = 0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic tk);
        cs = 1; we = 0; reg_addr = a; tick = tk;
        clk_step();
        cs = 0; tick = 0;
    endtask

    task automatic idle(input logic tk);
        tick = tk;
        clk_step();
        tick = 0;
    endtask

    task automatic do_reset();
        reset = 1; cs = 0; we = 0; tick = 0;
        clk_step();
        clk_step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_do: got %h expected 00", dout); end
        bus_rd(4'h4, 0);
        n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL reset_ta_lo: got %h expected ff", dout); end
        bus_rd(4'h5, 0);
        n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL reset_ta_hi: got %h expected ff", dout); end
        bus_rd(4'hD, 0);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_icr: got %h expected 00", dout); end
        bus_rd(4'h9, 0);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL unmapped_read: got %h expected 00", dout); end
    endtask

    task automatic test_periodic();
        int n;
        do_reset();
        bus_wr(4'h4, 8'h03, 0);
        bus_wr(4'h5, 8'h00, 0);
        bus_wr(4'hD, 8'h81, 0);
        bus_wr(4'hE, 8'h11, 0);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            idle(1);
            if (irq === 1'b1) n = i;
        end
        n_cmp++; if (n != 4) begin n_err++; $display("FAIL periodic_ticks: got %0d expected 4", n); end
        bus_rd(4'h4, 0);
        n_cmp++; if (dout !== 8'h03) begin n_err++; $display("FAIL periodic_reload: got %h expected 03", dout); end
        bus_rd(4'hD, 0);
        n_cmp++; if (dout !== 8'h81) begin n_err++; $display("FAIL periodic_icr: got %h expected 81", dout); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL periodic_irq_clr: got %b expected 0", irq); end
        bus_wr(4'hE, 8'h00, 0);
    endtask

    task automatic test_oneshot();
        int hits;
        do_reset();
        bus_wr(4'h4, 8'h03, 0);
        bus_wr(4'h5, 8'h00, 0);
        bus_wr(4'hD, 8'h81, 0);
        bus_wr(4'hE, 8'h19, 0);
        hits = 0;
        for (int i = 0; i < 14; i++) begin
            bus_rd(4'hD, 1);
            if (dout === 8'h81) hits++;
        end
        n_cmp++; if (hits != 1) begin n_err++; $display("FAIL oneshot_count: got %0d expected 1", hits); end
        bus_rd(4'hE, 0);
        n_cmp++; if (dout !== 8'h08) begin n_err++; $display("FAIL oneshot_cra: got %h expected 08", dout); end
        bus_rd(4'h4, 0);
        n_cmp++; if (dout !== 8'h03) begin n_err++; $display("FAIL oneshot_lo: got %h expected 03", dout); end
        bus_rd(4'h5, 0);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL oneshot_hi: got %h expected 00", dout); end
    endtask

    task automatic test_read_collision();
        do_reset();
        bus_wr(4'h4, 8'h03, 0);
        bus_wr(4'h5, 8'h00, 0);
        bus_wr(4'hD, 8'h81, 0);
        bus_wr(4'hE, 8'h11, 0);
        for (int i = 0; i < 3; i++) idle(1);
        bus_rd(4'hD, 1);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL collide_read: got %h expected 00", dout); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL collide_irq: got %b expected 1", irq); end
        bus_rd(4'hD, 0);
        n_cmp++; if (dout !== 8'h81) begin n_err++; $display("FAIL collide_next: got %h expected 81", dout); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL collide_clr: got %b expected 0", irq); end
        bus_wr(4'hE, 8'h00, 0);
    endtask

    task automatic test_mask();
        do_reset();
        bus_wr(4'h4, 8'h01, 0);
        bus_wr(4'h5, 8'h00, 0);
        bus_wr(4'hE, 8'h11, 0);
        idle(1);
        idle(1);
        bus_wr(4'hE, 8'h00, 0);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_off_irq: got %b expected 0", irq); end
        bus_wr(4'hD, 8'h81, 0);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mask_on_irq: got %b expected 1", irq); end
        bus_wr(4'hD, 8'h01, 0);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_clr_irq: got %b expected 0", irq); end
        bus_rd(4'hD, 0);
        n_cmp++; if (dout !== 8'h01) begin n_err++; $display("FAIL mask_icr: got %h expected 01", dout); end
    endtask

    task automatic test_cascade();
        int n;
        int exp_n;
        logic [7:0] exp_crb;
`ifdef CIA_TIMER_CASCADE_EN
        exp_n = 6; exp_crb = 8'h41;
`else
        exp_n = 3; exp_crb = 8'h01;
`endif
        do_reset();
        bus_wr(4'h4, 8'h01, 0);
        bus_wr(4'h5, 8'h00, 0);
        bus_wr(4'h6, 8'h02, 0);
        bus_wr(4'h7, 8'h00, 0);
        bus_wr(4'hD, 8'h82, 0);
        bus_wr(4'hE, 8'h11, 0);
        bus_wr(4'hF, 8'h51, 0);
        bus_rd(4'hF, 0);
        n_cmp++; if (dout !== exp_crb) begin n_err++; $display("FAIL cascade_crb: got %h expected %h", dout, exp_crb); end
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            idle(1);
            if (irq === 1'b1) n = i;
        end
        n_cmp++; if (n != exp_n) begin n_err++; $display("FAIL cascade_ticks: got %0d expected %0d", n, exp_n); end
        bus_wr(4'hE, 8'h00, 0);
        bus_wr(4'hF, 8'h00, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_wr(4'h4, 8'h02, 0);
        bus_wr(4'h5, 8'h00, 0);
        bus_wr(4'hD, 8'h81, 0);
        bus_wr(4'hE, 8'h11, 0);
        for (int i = 0; i < 4; i++) idle(1);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL midrst_pre_irq: got %b expected 1", irq); end
        reset = 1; cs = 1; we = 0; reg_addr = 4'h4; tick = 1;
        clk_step();
        reset = 0; cs = 0; tick = 0;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL midrst_do: got %h expected 00", dout); end
        bus_rd(4'hE, 0);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL midrst_cra: got %h expected 00", dout); end
        bus_rd(4'hD, 0);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL midrst_icr: got %h expected 00", dout); end
        bus_wr(4'hE, 8'h10, 0);
        bus_rd(4'h4, 0);
        n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL midrst_lat_lo: got %h expected ff", dout); end
        bus_rd(4'h5, 0);
        n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL midrst_lat_hi: got %h expected ff", dout); end
    endtask

    task automatic test_random();
        logic [3:0] addrs [8];
        addrs = '{4'h4, 4'h5, 4'h6, 4'h7, 4'hD, 4'hE, 4'hF, 4'h2};
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 999) == 0);
            cs       = ($urandom_range(0, 1) == 1);
            we       = ($urandom_range(0, 2) == 0);
            reg_addr = addrs[$urandom_range(0, 7)];
            tick     = ($urandom_range(0, 3) != 0);
            if (reg_addr == 4'h5 || reg_addr == 4'h7)      di = 8'($urandom_range(0, 1));
            else if (reg_addr == 4'h4 || reg_addr == 4'h6) di = 8'($urandom_range(0, 15));
            else                                           di = 8'($urandom);
            clk_step();
            n_cmp++; if (dout !== m_do) begin n_err++; $display("FAIL random_do cycle %0d: got %h expected %h", i, dout, m_do); end
            n_cmp++; if (irq !== m_irq()) begin n_err++; $display("FAIL random_irq cycle %0d: got %b expected %b", i, irq, m_irq()); end
        end
        reset = 0; cs = 0; we = 0; tick = 0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_read_collision();
        test_mask();
        test_cascade();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
